// File: rtl/uart_pkg.sv
// Shared UART constants: default generator geometry, reset divisor and
// the oversample counter width helper.
package uart_pkg;

    localparam int DEF_DIV_W        = 16;
    localparam int DEF_FRAC_W       = 4;
    localparam int DEF_OSR          = 16;
    localparam int DEF_RST_DIV_INT  = 130;  // 20 MHz / (9600 * 16) = 130.2
    localparam int DEF_RST_DIV_FRAC = 3;

    function automatic int os_cnt_w(input int osr);
        return $clog2(osr);
    endfunction

endpackage

// File: rtl/uart_frac_div.sv
// Fractional clock divider: integer period counter stretched by one cycle
// whenever the fractional accumulator carries, with a pending/active divisor pair.
module uart_frac_div
    import uart_pkg::*;
#(
    parameter int DIV_W        = DEF_DIV_W,
    parameter int FRAC_W       = DEF_FRAC_W,
    parameter int RST_DIV_INT  = DEF_RST_DIV_INT,
    parameter int RST_DIV_FRAC = DEF_RST_DIV_FRAC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              resync,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              div_pend,
    output logic              clear,
    output logic              tick
);

    logic [DIV_W-1:0]  act_int;
    logic [DIV_W-1:0]  pend_int;
    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] act_frac;
    logic [FRAC_W-1:0] pend_frac;
    logic [FRAC_W-1:0] acc;
    logic              ext;
    logic [DIV_W:0]    last;
    logic [FRAC_W:0]   acc_sum;
    logic              apply;

    // Period length is computed one bit wider so a full-scale divisor plus
    // the extension cycle cannot wrap.
    assign last    = {1'b0, act_int} + (DIV_W+1)'(ext) - (DIV_W+1)'(1);
    assign clear   = !en || resync || (act_int == '0);
    assign tick    = !clear && ({1'b0, cnt} == last);
    assign acc_sum = {1'b0, acc} + {1'b0, act_frac};
    assign apply   = (div_pend || div_load) && (tick || clear);

    always_ff @(posedge clk) begin
        if (rst) begin
            act_int  <= DIV_W'(RST_DIV_INT);
            act_frac <= FRAC_W'(RST_DIV_FRAC);
            div_pend <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            ext      <= 1'b0;
        end else begin
            if (clear) begin
                cnt <= '0;
                acc <= '0;
                ext <= 1'b0;
            end else if (tick) begin
                cnt <= '0;
                acc <= acc_sum[FRAC_W-1:0];
                ext <= acc_sum[FRAC_W];
            end else begin
                cnt <= cnt + DIV_W'(1);
            end

            // A load landing on the application edge bypasses the pending register.
            if (apply) begin
                act_int  <= div_load ? div_int  : pend_int;
                act_frac <= div_load ? div_frac : pend_frac;
                div_pend <= 1'b0;
            end else if (div_load) begin
                div_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (div_load) begin
            pend_int  <= div_int;
            pend_frac <= div_frac;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: fractional oversample tick plus mid-bit and end-of-bit
// ticks decoded from the oversample count, restartable through resync.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W        = DEF_DIV_W,
    parameter int FRAC_W       = DEF_FRAC_W,
    parameter int OSR          = DEF_OSR,
    parameter int RST_DIV_INT  = DEF_RST_DIV_INT,
    parameter int RST_DIV_FRAC = DEF_RST_DIV_FRAC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              resync,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    input  logic              div_load,
    output logic              div_pend,
    output logic              os_tick,
    output logic              mid_tick,
    output logic              bit_tick
);

    localparam int CW = os_cnt_w(OSR);
    localparam logic [CW-1:0] MID_IDX  = CW'(OSR/2 - 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(OSR - 1);

    logic [CW-1:0] os_cnt;
    logic          clear;
    logic          raw_tick;

    uart_frac_div #(
        .DIV_W        (DIV_W),
        .FRAC_W       (FRAC_W),
        .RST_DIV_INT  (RST_DIV_INT),
        .RST_DIV_FRAC (RST_DIV_FRAC)
    ) u_frac_div (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .resync   (resync),
        .div_int  (div_int),
        .div_frac (div_frac),
        .div_load (div_load),
        .div_pend (div_pend),
        .clear    (clear),
        .tick     (raw_tick)
    );

    // Decode uses the count before this tick advances it, so the Nth tick
    // of a bit carries index N-1.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            os_cnt   <= '0;
            os_tick  <= 1'b0;
            mid_tick <= 1'b0;
            bit_tick <= 1'b0;
        end else begin
            os_tick  <= raw_tick;
            mid_tick <= raw_tick && (os_cnt == MID_IDX);
            bit_tick <= raw_tick && (os_cnt == LAST_IDX);
            if (raw_tick) begin
                os_cnt <= (os_cnt == LAST_IDX) ? '0 : os_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: divisor table with hand-computed tick
// positions, plus resync, divisor update, zero divisor and reset sequences.
module tb_uart_baud_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        resync;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        div_pend;
    logic        os_tick;
    logic        mid_tick;
    logic        bit_tick;

    int checks   = 0;
    int failures = 0;

    uart_baud_gen dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .resync   (resync),
        .div_int  (div_int),
        .div_frac (div_frac),
        .div_load (div_load),
        .div_pend (div_pend),
        .os_tick  (os_tick),
        .mid_tick (mid_tick),
        .bit_tick (bit_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dint;
        int dfrac;
        int fos;
        int fmid;
        int fbit;
        int nos;
        int nbit;
    } vec_t;

    localparam int WIN = 200;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // First cycle (1-based from the call) of each tick kind and tick counts.
    task automatic run_first(input int n, output int fos, output int fmid, output int fbit,
                             output int nos, output int nbit);
        fos = -1; fmid = -1; fbit = -1; nos = 0; nbit = 0;
        for (int i = 1; i <= n; i++) begin
            step();
            if (os_tick) begin
                nos++;
                if (fos < 0) fos = i;
            end
            if (mid_tick && fmid < 0) fmid = i;
            if (bit_tick) begin
                nbit++;
                if (fbit < 0) fbit = i;
            end
        end
    endtask

    task automatic wait_os(input int lim, output int dt);
        dt = -1;
        for (int i = 1; i <= lim; i++) begin
            step();
            if (os_tick) begin
                dt = i;
                break;
            end
        end
    endtask

    // Load with en low (applies immediately), then raise en: the load edge is the restart.
    task automatic restart(input int n, input int f);
        en       = 1'b0;
        div_int  = 16'(n);
        div_frac = 4'(f);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        en       = 1'b1;
    endtask

    initial begin
        vec_t vecs[5];
        int   fos, fmid, fbit, nos, nbit;
        int   iv[33];
        int   dt, sum, n131, bad;

        vecs[0] = '{4,  0,  4,  32,  64, 50,  3};
        vecs[1] = '{1,  0,  1,   8,  16, 200, 12};
        vecs[2] = '{10, 0,  10,  80, 160, 20,  1};
        vecs[3] = '{5,  8,  5,   43,  87, 36,  2};
        vecs[4] = '{3,  15, 3,   30,  62, 51,  3};

        rst = 1'b1; en = 1'b0; resync = 1'b0;
        div_int = '0; div_frac = '0; div_load = 1'b0;
        step();
        step();
        check("rst_os_tick",  int'(os_tick),  0);
        check("rst_mid_tick", int'(mid_tick), 0);
        check("rst_bit_tick", int'(bit_tick), 0);
        check("rst_div_pend", int'(div_pend), 0);
        rst = 1'b0;
        step();

        // Reset divisor 130/3: intervals of 130/131, 3 long ones per 16.
        en = 1'b1;
        for (int j = 0; j < 33; j++) begin
            wait_os(200, dt);
            iv[j] = dt;
        end
        check("def_first_interval", iv[0], 130);
        bad = 0;
        for (int j = 1; j < 33; j++) begin
            if (iv[j] != 130 && iv[j] != 131) bad++;
        end
        check("def_interval_range_bad", bad, 0);
        for (int s = 1; s <= 17; s += 4) begin
            sum = 0; n131 = 0;
            for (int j = s; j < s + 16; j++) begin
                sum += iv[j];
                if (iv[j] == 131) n131++;
            end
            check("def_window_sum", sum, 2083);
            check("def_window_131", n131, 3);
        end

        for (int v = 0; v < 5; v++) begin
            restart(vecs[v].dint, vecs[v].dfrac);
            run_first(WIN, fos, fmid, fbit, nos, nbit);
            check($sformatf("vec%0d_first_os", v),  fos,  vecs[v].fos);
            check($sformatf("vec%0d_first_mid", v), fmid, vecs[v].fmid);
            check($sformatf("vec%0d_first_bit", v), fbit, vecs[v].fbit);
            check($sformatf("vec%0d_n_os", v),      nos,  vecs[v].nos);
            check($sformatf("vec%0d_n_bit", v),     nbit, vecs[v].nbit);
        end

        // resync on the would-be tick edge suppresses it and restarts phase
        restart(10, 0);
        run_first(10, fos, fmid, fbit, nos, nbit);
        check("rs_first_os", fos, 10);
        for (int i = 0; i < 9; i++) step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        check("rs_suppressed_tick", int'(os_tick), 0);
        run_first(15, fos, fmid, fbit, nos, nbit);
        check("rs_next_os", fos, 10);
        // resync mid-period
        resync = 1'b1;
        step();
        resync = 1'b0;
        run_first(90, fos, fmid, fbit, nos, nbit);
        check("rs_mid_next_os", fos, 10);
        check("rs_mid_next_mid", fmid, 80);

        // Divisor 20 loaded at cnt=3 takes effect after the current 10-cycle period
        restart(10, 0);
        run_first(10, fos, fmid, fbit, nos, nbit);
        for (int i = 0; i < 3; i++) step();
        div_int = 16'd20; div_frac = 4'd0; div_load = 1'b1;
        step();
        div_load = 1'b0;
        check("upd_pend_set", int'(div_pend), 1);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (os_tick || !div_pend) bad++;
        end
        check("upd_pend_hold_bad", bad, 0);
        step();
        check("upd_old_period_tick", int'(os_tick), 1);
        check("upd_pend_clear", int'(div_pend), 0);
        run_first(20, fos, fmid, fbit, nos, nbit);
        check("upd_new_period_a", fos, 20);
        run_first(20, fos, fmid, fbit, nos, nbit);
        check("upd_new_period_b", fos, 20);

        // Second load before application overwrites the pending value
        restart(50, 0);
        for (int i = 0; i < 5; i++) step();
        div_int = 16'd7; div_load = 1'b1;
        step();
        div_int = 16'd9;
        step();
        div_load = 1'b0;
        run_first(43, fos, fmid, fbit, nos, nbit);
        check("ovw_old_period", fos, 43);
        run_first(9, fos, fmid, fbit, nos, nbit);
        check("ovw_new_period", fos, 9);

        // Zero divisor holds everything idle; then 1/0 ticks every cycle
        restart(0, 5);
        run_first(50, fos, fmid, fbit, nos, nbit);
        check("zero_n_os", nos, 0);
        check("zero_n_bit", nbit, 0);
        check("zero_pend", int'(div_pend), 0);
        div_int = 16'd1; div_frac = 4'd0; div_load = 1'b1;
        step();
        div_load = 1'b0;
        check("one_pend_applied", int'(div_pend), 0);
        run_first(48, fos, fmid, fbit, nos, nbit);
        check("one_first_os", fos, 1);
        check("one_n_os", nos, 48);
        check("one_first_bit", fbit, 16);
        check("one_n_bit", nbit, 3);

        // rst while ticking every cycle: ticks drop, divisor reverts to 130
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_run_os_tick", int'(os_tick), 0);
        run_first(140, fos, fmid, fbit, nos, nbit);
        check("rst_run_first_os", fos, 130);
        // A pending divisor is discarded by reset
        for (int i = 0; i < 20; i++) step();
        div_int = 16'd9; div_frac = 4'd0; div_load = 1'b1;
        step();
        div_load = 1'b0;
        check("rst_pend_before", int'(div_pend), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_pend_after", int'(div_pend), 0);
        run_first(140, fos, fmid, fbit, nos, nbit);
        check("rst_pend_first_os", fos, 130);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Parametrised fractional baud generator for the UART. It produces an oversample tick (`os_tick`), a mid-bit sample tick and a bit tick from `clk`, using a programmable integer-plus-fractional divisor. Phase restart via `resync` lets the RX aligner lock the sample point to a start-bit edge. It feeds the UART TX/RX engines and replaces the fixed integer divider.

## Interface
- `DIV_W`, 16: width of the integer divisor.
- `FRAC_W`, 4: width of the fractional divisor, in units of 1/2^FRAC_W clk.
- `OSR`, 16: oversample ratio, an even value in the range 4..32.
- `RST_DIV_INT`, 130: integer divisor loaded at reset (20 MHz, 9600 Bd, OSR 16).
- `RST_DIV_FRAC`, 3: fractional divisor loaded at reset.
- `clk` in 1: clock, clk.
- `rst` in 1: reset rst, synchronous, active-high.
- `en` in 1: generator enable.
- `resync` in 1: single-cycle pulse that restarts phase.
- `div_int` in DIV_W: new integer divisor.
- `div_frac` in FRAC_W: new fractional divisor.
- `div_load` in 1: strobe that captures `div_int`/`div_frac` into the pending register.
- `div_pend` out 1: high while a captured divisor is not yet active.
- `os_tick` out 1: oversample tick, one cycle wide.
- `mid_tick` out 1: tick at the centre of the bit.
- `bit_tick` out 1: tick at the end of the bit.

## Operation
- Active divisor is N = act_int and F = act_frac. Average `os_tick` period is N + F/2^FRAC_W cycles.
- Period counter `cnt` counts 0..P-1. P = N, or N+1 when the previous `os_tick` produced a carry out of the fractional accumulator.
- Accumulator `acc` (FRAC_W bits): `acc <= acc + F` on each `os_tick`. The carry out sets the extend flag for the next period only.
- Oversample counter `os_cnt` counts 0..OSR-1 and advances on each `os_tick`.
  - `mid_tick` = `os_tick` while `os_cnt` == OSR/2-1.
  - `bit_tick` = `os_tick` while `os_cnt` == OSR-1.
- Clear condition is `en`=0, or `resync`=1, or act_int=0. It clears `cnt`, `os_cnt`, `acc` and the extend flag, and forces all ticks to 0.
  - Clear takes priority over period end.
  - A rising edge of `en` is therefore a restart.
- act_int = 1 with F = 0 gives `os_tick` every cycle.
- Divisor update:
  - `div_load` writes the pending register and sets `div_pend`.
  - The pending value becomes active at the next period-end edge, or at the next edge while the clear condition holds.
  - Application clears `div_pend`. `acc` is preserved.
  - If `div_load` coincides with application, the newly loaded value is the one applied.
  - A second `div_load` before application overwrites the pending value.
- Reset: the active divisor is set to RST_DIV_INT/RST_DIV_FRAC and all counters are cleared.
- Arithmetic is unsigned. N+1 is computed at DIV_W+1 bits, so N = 2^DIV_W-1 with extension does not wrap.

## Timing
- All outputs are registered. Reset value of every output is 0, including `div_pend`.
- Let edge k be the last edge at which the clear condition held. The first `os_tick` is high in the cycle after edge k+P. Subsequent `os_tick`s follow every P cycles.
- With F = 0:
  - first `mid_tick` is (OSR/2)·N cycles after restart;
  - first `bit_tick` is OSR·N cycles after restart;
  - both repeat every OSR·N cycles.
- `resync` asserted in the same cycle as a would-be `os_tick` suppresses that tick.
- `rst` during operation: all ticks are low in the cycle after the reset edge and the divisor reverts to the reset values.

## Structure
- Shared package `uart_pkg` holds:
  - default DIV_W, FRAC_W and OSR;
  - the reset divisor constants RST_DIV_INT/RST_DIV_FRAC;
  - a localparam function computing the `os_cnt` width, $clog2(OSR).
- Sub-module `uart_frac_div` holds `cnt`, `acc`, the extend flag and the active/pending divisor registers, and outputs a raw `os_tick`.
- Top level holds `os_cnt`, the clear logic and tick decode.

## Test plan
- After reset, `en`=1 with defaults 130/3: successive `os_tick` intervals are only 130 or 131. Any 16 consecutive intervals total 2083 cycles, with 131 occurring exactly 3 times.
- `div_load` 4/0, `en` rising: `os_tick` every 4 cycles, first at 4. `mid_tick` at 32 and `bit_tick` at 64, then every 64 cycles.
- Divisor 10/0 running, `resync` pulsed mid-period: no tick in that cycle. Next `os_tick` comes exactly 10 cycles later and `mid_tick` 80 cycles later.
- Divisor 10/0 running, `div_load` 20/0 at cnt=3: `div_pend` is high until period end. The current period stays 10 and the following periods are 20.
- `div_load` 0/x: no ticks and counters held at 0. Then `div_load` 1/0: `os_tick` high every cycle and `bit_tick` every 16 cycles.
- `rst` asserted mid-bit with `en`=1: ticks are 0 from the next cycle. After `rst` is released, the period reverts to 130/131.
